// File: rtl/hdr_stats_scheduler_pkg.sv
// Shared types and constants for the HDR statistics scheduler.
// Used by the scheduler RTL and its bench.
package hdr_stats_pkg;

  localparam int STAT_W = 8;
  localparam int DEF_LPF = 720;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  typedef struct packed {
    logic [STAT_W-1:0] min;
    logic [STAT_W-1:0] max;
    logic [STAT_W-1:0] diff;
  } stat_t;

endpackage

// File: rtl/hdr_stats_scheduler_if.sv
// Publish channel from the scheduler to the
// tone-mapping / exposure-control consumer.
interface hdr_stats_scheduler_if #(
  parameter int W  = 8,
  parameter int EW = 2
);

  logic          valid;
  logic          ready;
  logic [EW-1:0] exp;
  logic [W-1:0]  min;
  logic [W-1:0]  max;
  logic [W-1:0]  diff;

  modport master (
    output valid, exp, min, max, diff,
    input  ready
  );

  modport slave (
    input  valid, exp, min, max, diff,
    output ready
  );

endinterface

// File: rtl/hdr_stats_scheduler_bank.sv
// Per-exposure min/max result bank with a
// registered read port (old data on same-cycle write).
module stats_bank #(
  parameter int W  = 8,
  parameter int EW = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [EW-1:0] waddr,
  input  logic [W-1:0]  wmin,
  input  logic [W-1:0]  wmax,
  input  logic [EW-1:0] raddr,
  output logic [W-1:0]  rmin,
  output logic [W-1:0]  rmax
);

  localparam int N = 2 ** EW;

  logic [W-1:0] mem_min [N];
  logic [W-1:0] mem_max [N];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        mem_min[i] <= '0;
        mem_max[i] <= '0;
      end
      rmin <= '0;
      rmax <= '0;
    end else begin
      if (we) begin
        mem_min[waddr] <= wmin;
        mem_max[waddr] <= wmax;
      end
      rmin <= mem_min[raddr];
      rmax <= mem_max[raddr];
    end
  end

endmodule

// File: rtl/hdr_stats_scheduler.sv
// Frame sequencer for the shared min/max detector across
// interleaved HDR exposures; publishes per-exposure results.
module hdr_stats_scheduler
  import hdr_stats_pkg::*;
#(
  parameter int W   = 8,
  parameter int LW  = 11,
  parameter int EW  = 2,
  parameter int FCW = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           enable,
  input  logic [LW-1:0]  lines_per_frame,
  input  logic           sop,
  input  logic           eop,
  input  logic           valid,
  input  logic [EW-1:0]  exp_id,
  output logic           det_frame_start,
  output logic           det_frame_end,
  output logic           det_valid,
  input  logic [W-1:0]   det_min,
  input  logic [W-1:0]   det_max,
  input  logic [W-1:0]   det_diff,
  hdr_stats_scheduler_if.master stat,
  input  logic [EW-1:0]  rd_idx,
  output logic [W-1:0]   rd_min,
  output logic [W-1:0]   rd_max,
  output logic [FCW-1:0] frame_cnt,
  output logic           overrun,
  input  logic           overrun_clr
);

  state_t        state_q, state_d;
  logic [LW-1:0] line_q, line_d;
  logic [LW-1:0] lpf_q, lpf_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [LW-1:0] new_lpf, lpf_eff, line_eff;
  logic          start, counting, last, capture;

  assign det_valid = valid;

  // a zero height would never terminate; run it as one line
  assign new_lpf  = (lines_per_frame == '0) ? LW'(1)
                                            : lines_per_frame;
  assign start    = sop && enable && (state_q != ACTIVE);
  assign counting = start || (state_q == ACTIVE);
  assign lpf_eff  = start ? new_lpf : lpf_q;
  assign line_eff = start ? '0 : line_q;
  assign last     = eop && counting &&
                    (line_eff == lpf_eff - LW'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      line_q  <= '0;
      lpf_q   <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      lpf_q   <= lpf_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    lpf_d   = lpf_q;
    exp_d   = exp_q;
    unique case (state_q)
      IDLE:    ;
      ACTIVE:  ;
      CAPTURE: begin
        state_d = enable ? ACTIVE : IDLE;
        line_d  = '0;
      end
      default: state_d = IDLE;
    endcase
    // sop is resolved before eop so 1-pixel lines work
    if (start) begin
      state_d = ACTIVE;
      line_d  = '0;
      lpf_d   = new_lpf;
      exp_d   = exp_id;
    end
    if (eop && counting) begin
      if (last) begin
        state_d = CAPTURE;
        line_d  = '0;
      end else begin
        line_d = line_eff + LW'(1);
      end
    end
  end

  always_comb begin
    det_frame_start = start;
    det_frame_end   = last;
    capture         = (state_q == CAPTURE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat.valid <= 1'b0;
      stat.exp   <= '0;
      stat.min   <= '0;
      stat.max   <= '0;
      stat.diff  <= '0;
      frame_cnt  <= '0;
      overrun    <= 1'b0;
    end else begin
      if (capture) begin
        stat.valid <= 1'b1;
        stat.exp   <= exp_q;
        stat.min   <= det_min;
        stat.max   <= det_max;
        stat.diff  <= det_diff;
        frame_cnt  <= frame_cnt + FCW'(1);
      end else if (stat.valid && stat.ready) begin
        stat.valid <= 1'b0;
      end
      if (capture && stat.valid && !stat.ready)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
    end
  end

  stats_bank #(
    .W  (W),
    .EW (EW)
  ) u_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (capture),
    .waddr   (exp_q),
    .wmin    (det_min),
    .wmax    (det_max),
    .raddr   (rd_idx),
    .rmin    (rd_min),
    .rmax    (rd_max)
  );

endmodule

// File: tb/tb_hdr_stats_scheduler.sv
// Directed and random bench for hdr_stats_scheduler with a
// frame-level reference model checked every cycle.
module tb_hdr_stats_scheduler;
  import hdr_stats_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [10:0] lines_per_frame;
  logic        sop, eop, valid;
  logic [1:0]  exp_id;
  logic        det_frame_start, det_frame_end, det_valid;
  logic [7:0]  det_min, det_max, det_diff;
  logic [1:0]  rd_idx;
  logic [7:0]  rd_min, rd_max;
  logic [15:0] frame_cnt;
  logic        overrun, overrun_clr;

  hdr_stats_scheduler_if #(.W(8), .EW(2)) st ();

  hdr_stats_scheduler dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .lines_per_frame (lines_per_frame),
    .sop             (sop),
    .eop             (eop),
    .valid           (valid),
    .exp_id          (exp_id),
    .det_frame_start (det_frame_start),
    .det_frame_end   (det_frame_end),
    .det_valid       (det_valid),
    .det_min         (det_min),
    .det_max         (det_max),
    .det_diff        (det_diff),
    .stat            (st),
    .rd_idx          (rd_idx),
    .rd_min          (rd_min),
    .rd_max          (rd_max),
    .frame_cnt       (frame_cnt),
    .overrun         (overrun),
    .overrun_clr     (overrun_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit rnd = 0;
  bit s, e;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, req, $time);
    end
  endtask

  // frame-level reference model
  bit          open_m, cap_m, sv_m, ovr_m;
  int          lpf_m, lines_m;
  logic [1:0]  cexp_m, pexp_m;
  stat_t       bank_m [4];
  stat_t       pub_m;
  logic [15:0] fc_m;
  logic [7:0]  rdmin_m, rdmax_m;

  always @(negedge clk) begin
    int  nl;
    bit  es, ee, was_open, ncap;
    if (!reset_n) begin
      open_m = 0; cap_m = 0; sv_m = 0; ovr_m = 0;
      lpf_m = 0; lines_m = 0; cexp_m = 0; pexp_m = 0;
      for (int i = 0; i < 4; i++) bank_m[i] = '0;
      pub_m = '0; fc_m = 0; rdmin_m = 0; rdmax_m = 0;
    end else begin
      nl = (lines_per_frame == 0) ? 1 : int'(lines_per_frame);
      es = sop && enable && !open_m;
      ee = eop && (es ? (nl == 1)
                      : (open_m && lines_m + 1 == lpf_m));
      chk("m_start", det_frame_start, es);
      chk("m_end", det_frame_end, ee);
      chk("m_valid", st.valid, sv_m);
      if (sv_m) begin
        chk("m_exp", st.exp, pexp_m);
        chk("m_min", st.min, pub_m.min);
        chk("m_max", st.max, pub_m.max);
        chk("m_diff", st.diff, pub_m.diff);
      end
      chk("m_fcnt", frame_cnt, fc_m);
      chk("m_ovr", overrun, ovr_m);
      chk("m_rdmin", rd_min, rdmin_m);
      chk("m_rdmax", rd_max, rdmax_m);
      chk("m_dvalid", det_valid, valid);
      // advance one clock
      rdmin_m = bank_m[rd_idx].min;
      rdmax_m = bank_m[rd_idx].max;
      if (cap_m) begin
        bank_m[cexp_m] = '{det_min, det_max, det_diff};
        pub_m  = '{det_min, det_max, det_diff};
        pexp_m = cexp_m;
        if (sv_m && !st.ready) ovr_m = 1;
        else if (overrun_clr) ovr_m = 0;
        sv_m = 1;
        fc_m = fc_m + 1;
      end else begin
        if (sv_m && st.ready) sv_m = 0;
        if (overrun_clr) ovr_m = 0;
      end
      was_open = open_m;
      ncap = 0;
      if (es) begin
        cexp_m = exp_id; lpf_m = nl; lines_m = 0; open_m = 1;
      end else if (cap_m) begin
        open_m = enable; lines_m = 0;
      end
      if (eop && (es || was_open)) begin
        lines_m++;
        if (lines_m == lpf_m) begin
          open_m = 0; lines_m = 0; ncap = 1;
        end
      end
      cap_m = ncap;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) begin
      st.ready    = 1'($urandom);
      overrun_clr = ($urandom_range(0, 7) == 0);
      rd_idx      = 2'($urandom);
      det_min     = 8'($urandom);
      det_max     = 8'($urandom);
      det_diff    = 8'($urandom);
    end
  endtask

  task automatic line(input int npix, input int gap,
                      output bit so, output bit eo);
    so = 0;
    eo = 0;
    for (int i = 0; i < npix; i++) begin
      sop = (i == 0);
      eop = (i == npix - 1);
      valid = 1;
      #1;
      so |= det_frame_start;
      eo |= det_frame_end;
      tick();
    end
    sop = 0; eop = 0; valid = 0;
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic set_det(input int a, input int b, input int c);
    det_min = 8'(a); det_max = 8'(b); det_diff = 8'(c);
  endtask

  initial begin
    reset_n = 0; enable = 0; lines_per_frame = 4;
    sop = 0; eop = 0; valid = 0; exp_id = 0;
    set_det(0, 0, 0);
    st.ready = 0; rd_idx = 0; overrun_clr = 0;
    tick(); tick();
    chk("rst_valid", st.valid, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_rdmin", rd_min, 0);
    reset_n = 1;
    tick();

    // basic 4-line frame
    enable = 1; lines_per_frame = 4; exp_id = 1;
    set_det(10, 200, 190);
    line(3, 1, s, e);
    chk("t1_start", s, 1);
    chk("t1_no_early_end", e, 0);
    line(3, 1, s, e);
    line(3, 1, s, e);
    line(3, 0, s, e);
    chk("t1_end", e, 1);
    enable = 0;
    chk("t1_valid_lat", st.valid, 0);
    tick();
    chk("t1_valid", st.valid, 1);
    chk("t1_exp", st.exp, 1);
    chk("t1_min", st.min, 10);
    chk("t1_max", st.max, 200);
    chk("t1_diff", st.diff, 190);
    chk("t1_fcnt", frame_cnt, 1);
    st.ready = 1; tick(); st.ready = 0;
    chk("t1_consumed", st.valid, 0);

    // back-to-back frames, consumer stalled
    enable = 1; lines_per_frame = 2; exp_id = 0;
    set_det(20, 30, 10);
    line(2, 1, s, e);
    exp_id = 3;
    line(2, 0, s, e);
    line(2, 1, s, e);
    chk("t2_restart", s, 1);
    chk("t2_a_exp", st.exp, 0);
    chk("t2_a_min", st.min, 20);
    chk("t2_a_ovr", overrun, 0);
    set_det(40, 90, 50);
    line(2, 0, s, e);
    enable = 0;
    tick();
    chk("t2_ovr", overrun, 1);
    chk("t2_b_exp", st.exp, 3);
    chk("t2_b_min", st.min, 40);
    chk("t2_fcnt", frame_cnt, 3);
    overrun_clr = 1; tick(); overrun_clr = 0;
    chk("t2_clr", overrun, 0);
    overrun_clr = 1; enable = 1;
    lines_per_frame = 1; exp_id = 1;
    line(2, 0, s, e);
    chk("t2_1line_end", e, 1);
    enable = 0;
    tick();
    overrun_clr = 0;
    chk("t2_set_wins", overrun, 1);

    // accept in the same cycle as a new capture
    overrun_clr = 1; tick(); overrun_clr = 0;
    enable = 1; lines_per_frame = 2; exp_id = 2;
    set_det(5, 50, 45);
    line(2, 1, s, e);
    line(2, 0, s, e);
    st.ready = 1; enable = 0;
    tick();
    st.ready = 0;
    chk("t3_valid", st.valid, 1);
    chk("t3_ovr", overrun, 0);
    chk("t3_exp", st.exp, 2);
    chk("t3_min", st.min, 5);
    chk("t3_fcnt", frame_cnt, 5);
    st.ready = 1; tick(); st.ready = 0;

    // single-pixel single-line frames, lpf 1 and 0
    enable = 1; lines_per_frame = 1; exp_id = 0;
    line(1, 0, s, e);
    chk("t4_l1_start", s, 1);
    chk("t4_l1_end", e, 1);
    enable = 0; tick();
    enable = 1; lines_per_frame = 0;
    line(1, 0, s, e);
    chk("t4_l0_start", s, 1);
    chk("t4_l0_end", e, 1);
    enable = 0; tick();
    chk("t4_fcnt", frame_cnt, 7);
    st.ready = 1; tick(); st.ready = 0;
    overrun_clr = 1; tick(); overrun_clr = 0;

    // enable dropped mid-frame
    enable = 1; lines_per_frame = 4; exp_id = 3;
    line(2, 1, s, e);
    enable = 0;
    line(2, 1, s, e);
    line(2, 1, s, e);
    line(2, 0, s, e);
    chk("t5_end", e, 1);
    tick();
    chk("t5_fcnt", frame_cnt, 8);
    chk("t5_valid", st.valid, 1);
    chk("t5_exp", st.exp, 3);
    line(2, 1, s, e);
    chk("t5_no_start", s, 0);

    // reset in the middle of a frame
    enable = 1; lines_per_frame = 3; exp_id = 1;
    line(2, 1, s, e);
    line(2, 1, s, e);
    reset_n = 0;
    #1;
    chk("t6_valid", st.valid, 0);
    chk("t6_fcnt", frame_cnt, 0);
    chk("t6_ovr", overrun, 0);
    chk("t6_rdmax", rd_max, 0);
    tick(); tick();
    reset_n = 1;
    tick();
    lines_per_frame = 2; exp_id = 2;
    set_det(33, 99, 66);
    line(2, 1, s, e);
    chk("t6_fresh_start", s, 1);
    line(2, 0, s, e);
    chk("t6_end", e, 1);
    enable = 0; rd_idx = 2;
    tick();
    chk("t6_rd_old", rd_min, 0);
    tick();
    chk("t6_rdmin", rd_min, 33);
    chk("t6_rdmax", rd_max, 99);
    chk("t6_fcnt", frame_cnt, 1);

    // randomized streaming
    rnd = 1;
    enable = 1;
    for (int n = 0; n < 900; n++) begin
      if ($urandom_range(0, 9) == 0) enable = ~enable;
      lines_per_frame = 11'($urandom_range(0, 4));
      exp_id = 2'($urandom);
      line($urandom_range(1, 4), $urandom_range(0, 2), s, e);
    end
    rnd = 0;
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/hdr_stats_scheduler.md
Name: hdr_stats_scheduler

Overview:
- Sequences the shared per-frame min/max statistics detector across interleaved HDR exposures.
- Tracks line and frame boundaries of the incoming stream and issues frame start/end strobes to the detector.
- Captures the detector's min/max/diff result per exposure and publishes it to the tone-mapping/exposure-control consumer over a valid/ready handshake.
- Sits between the camera line-framing logic and the detector/consumer pair.

Parameters:
W, 8, pixel/statistic width
LW, 11, line counter width
EW, 2, exposure id width; number of exposures NUM_EXP = 2**EW
FCW, 16, frame counter width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous reset, active-low
enable  in  1  run enable; checked at frame start
lines_per_frame  in  LW  frame height in lines; latched at frame start
sop  in  1  start of line, first pixel
eop  in  1  end of line, last pixel
valid  in  1  pixel valid, forwarded unchanged to detector
exp_id  in  EW  exposure tag; latched at frame start
det_frame_start  out  1  comb; high on the first sop of a frame
det_frame_end  out  1  comb; high on the eop of the last line
det_min  in  W  detector result, valid the cycle after det_frame_end
det_max  in  W  detector result
det_diff  in  W  detector result
stat_valid  out  1  result available
stat_ready  in  1  consumer accepts
stat_exp  out  EW  exposure of published result
stat_min  out  W  published min
stat_max  out  W  published max
stat_diff  out  W  published max-min
rd_idx  in  EW  bank read index
rd_min  out  W  bank[rd_idx] min, 1-cycle registered read
rd_max  out  W  bank[rd_idx] max, 1-cycle registered read
frame_cnt  out  FCW  completed frames, wraps
overrun  out  1  sticky: unconsumed result overwritten
overrun_clr  in  1  clears overrun

Behaviour:
- Reset: state IDLE; line_cnt, frame_cnt and all outputs 0; overrun 0; bank entries 0.
- States IDLE, ACTIVE, CAPTURE.
- IDLE:
  - sop && enable → det_frame_start=1 same cycle.
  - Latch exp_id as cur_exp and lines_per_frame as cur_lpf. A value of 0 is treated as 1.
  - line_cnt=0, go ACTIVE. eop in IDLE is ignored.
- ACTIVE:
  - Each eop increments line_cnt.
  - eop && line_cnt==cur_lpf-1 → det_frame_end=1 same cycle, line_cnt<=0, go CAPTURE.
  - sop && eop in the same cycle (1-pixel line): sop handled first, then eop.
  - Single-line frame: det_frame_start and det_frame_end both high in the same cycle.
- CAPTURE (exactly 1 cycle):
  - Sample det_min/max/diff into bank[cur_exp] and into the publish registers.
  - stat_exp<=cur_exp, stat_valid<=1, frame_cnt++.
  - Next state ACTIVE with line_cnt 0 if enable, else IDLE.
  - A sop arriving during CAPTURE is a first-line sop: with enable=1 it asserts det_frame_start and relatches exp_id/lpf. With enable=0 it is ignored.
- enable deasserted mid-frame: the current frame completes normally, then IDLE.
- lines_per_frame or exp_id changes mid-frame have no effect until the next frame start.
- Publish handshake:
  - stat_valid stays high and stat_* stay stable until stat_valid && stat_ready.
  - The transfer clears stat_valid the next cycle unless CAPTURE loads new data in that same cycle; then valid stays 1, no overrun.
- Overrun:
  - CAPTURE while stat_valid=1 and stat_ready=0 overwrites the publish registers and sets overrun.
  - overrun_clr clears it; a simultaneous set wins.
- rd_min/rd_max: registered read of bank[rd_idx] with 1-cycle latency. A same-cycle bank write returns the old value.
- Reset mid-frame: state returns to IDLE immediately (async); stat_valid drops; the partial frame is discarded.

Decomposition:
- Shared package hdr_stats_pkg:
  - state enum typedef (IDLE/ACTIVE/CAPTURE)
  - stat_t struct {min, max, diff}
  - default frame-height constant 720
- Natural sub-module: stats_bank, the NUM_EXP-entry register bank with write port and 1-cycle registered read.

Test Plan:
- lpf=4, exp_id=1, enable=1, 4 lines; detector model returns min 10, max 200, diff 190 → det_frame_start on first sop, det_frame_end on 4th eop; stat_valid 2 cycles after that eop with stat_exp=1, 10/200/190; frame_cnt=1.
- Two frames, exp 0 then 3, stat_ready held low → second CAPTURE overwrites with exp=3 data, overrun=1; overrun_clr pulse → 0; set and clear in the same cycle → stays 1.
- stat_ready=1 in the same cycle as CAPTURE → new data published, stat_valid stays 1, overrun stays 0.
- lpf=1, single-pixel line (sop=eop=1) → det_frame_start and det_frame_end both high that cycle; lpf=0 behaves identically.
- enable dropped on line 2 of a 4-line frame → frame completes and publishes; next sop gives no det_frame_start; state IDLE.
- reset_n asserted mid-frame → outputs 0 immediately; next sop starts a fresh frame with line_cnt 0; after writing exp 2, rd_idx=2 gives rd_min/rd_max one cycle later.
